// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue queue: op encodings, the IEEE-754 double
// exponent limit, the sequencer state type and classification helpers.
package fpu_pkg;

    localparam logic [1:0]  OP_ADD  = 2'b00;
    localparam logic [1:0]  OP_SUB  = 2'b01;
    localparam logic [1:0]  OP_MUL  = 2'b10;
    localparam logic [1:0]  OP_DIV  = 2'b11;

    localparam logic [10:0] EXP_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StHold = 2'd2
    } fsm_state_e;

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == EXP_MAX) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic is_inf(input logic [63:0] x);
        return (x[62:52] == EXP_MAX) && (x[51:0] == 52'd0);
    endfunction

    function automatic logic is_zero(input logic [63:0] x);
        return (x[62:52] == 11'd0) && (x[51:0] == 52'd0);
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous show-ahead FIFO. Full/empty come from the occupancy counter so the
// pointers can be plain log2(DEPTH)-bit values that wrap on their own.
module fpu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpu_issue_queue.sv
// Issue stage in front of a combinational FPU. Requests are queued, presented one
// at a time on registered operand ports, and the FPU result is captured FPU_LAT
// cycles later and returned in order with its tag and class flags.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned FPU_LAT = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [TAG_W-1:0]       in_tag_i,
    input  logic [1:0]             in_op_i,
    input  logic [63:0]            in_a_i,
    input  logic [63:0]            in_b_i,
    output logic [63:0]            fpu_a_o,
    output logic [63:0]            fpu_b_o,
    output logic [1:0]             fpu_op_o,
    input  logic [63:0]            fpu_result_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [TAG_W-1:0]       out_tag_o,
    output logic [63:0]            out_result_o,
    output logic                   out_nan_o,
    output logic                   out_inf_o,
    output logic                   out_zero_o,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic                   busy_o
);

    localparam int unsigned ENTRY_W = TAG_W + 2 + 128;
    localparam int unsigned CNT_W   = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_LAT - 1);

    fsm_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TAG_W-1:0]   tag_q;
    logic [63:0]        fpu_a_q, fpu_b_q;
    logic [1:0]         fpu_op_q;
    logic               out_valid_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic [63:0]        out_result_q;
    logic               out_nan_q, out_inf_q, out_zero_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

    assign fifo_wdata = {in_tag_i, in_op_i, in_a_i, in_b_i};
    assign fifo_push  = in_valid_i && !fifo_full;
    assign in_ready_o = !fifo_full;

    fpu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy_o)
    );

    // Pop when idle, or when the held result is taken and another request waits.
    always_comb begin
        fifo_pop = 1'b0;
        case (state_q)
            StIdle:  fifo_pop = !fifo_empty;
            StHold:  fifo_pop = out_valid_q && out_ready_i && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Sequencer: operand load on pop, latency count, result capture and handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tag_q        <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= '0;
            out_valid_q  <= 1'b0;
            out_tag_q    <= '0;
            out_result_q <= '0;
            out_nan_q    <= 1'b0;
            out_inf_q    <= 1'b0;
            out_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (fifo_pop) begin
                        {tag_q, fpu_op_q, fpu_a_q, fpu_b_q} <= fifo_rdata;
                        cnt_q   <= '0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (cnt_q == CNT_LAST) begin
                        out_tag_q    <= tag_q;
                        out_result_q <= fpu_result_i;
                        out_nan_q    <= is_nan(fpu_result_i);
                        out_inf_q    <= is_inf(fpu_result_i);
                        out_zero_q   <= is_zero(fpu_result_i);
                        out_valid_q  <= 1'b1;
                        state_q      <= StHold;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        if (fifo_pop) begin
                            {tag_q, fpu_op_q, fpu_a_q, fpu_b_q} <= fifo_rdata;
                            cnt_q   <= '0;
                            state_q <= StExec;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fpu_a_o      = fpu_a_q;
    assign fpu_b_o      = fpu_b_q;
    assign fpu_op_o     = fpu_op_q;
    assign out_valid_o  = out_valid_q;
    assign out_tag_o    = out_tag_q;
    assign out_result_o = out_result_q;
    assign out_nan_o    = out_nan_q;
    assign out_inf_o    = out_inf_q;
    assign out_zero_o   = out_zero_q;
    assign busy_o       = (state_q != StIdle) || !fifo_empty;

endmodule
